// File: rtl/cadu_pkg.sv
// Shared types and width helpers for the CADU attached-sync-marker search.
package cadu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [63:0] DEFAULT_ASM = 64'h1ACFFC1D;

    function automatic int ofs_width(input int bits_per_frame);
        return $clog2(bits_per_frame);
    endfunction

    function automatic int acc_width(input int num_frames, input int sync_w);
        return $clog2(num_frames * sync_w + 1);
    endfunction

endpackage

// File: rtl/asm_popcount_corr.sv
// Counts the bits of a window that agree with the sync marker; result registered (latency 1).
module asm_popcount_corr
    import cadu_pkg::*;
#(
    parameter int          SYNC_W    = 32,
    parameter logic [63:0] SYNC_WORD = DEFAULT_ASM
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic [SYNC_W-1:0]           window,
    output logic [$clog2(SYNC_W+1)-1:0] score
);

    localparam int SC_W = $clog2(SYNC_W + 1);
    localparam logic [SYNC_W-1:0] ASM = SYNC_WORD[SYNC_W-1:0];

    logic [SYNC_W-1:0] agree;
    logic [SC_W-1:0]   sum;

    always_comb begin
        agree = ~(window ^ ASM);
        sum   = '0;
        for (int i = 0; i < SYNC_W; i++) begin
            sum = sum + SC_W'(agree[i]);
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            score <= '0;
        end else begin
            score <= sum;
        end
    end

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Read-first true dual-port RAM; both write ports commit on clka, so callers tie clka and clkb together.
module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024
) (
    input  logic                         clka,
    input  logic                         clkb,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end
            douta <= mem[addra];
        end
        if (enb && web) begin
            mem[addrb] <= dinb;
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/cadu_asm_search.sv
// ASM acquisition: per-offset correlation scores accumulated over several frames,
// best offset/polarity picked on the final pass.
module cadu_asm_search
    import cadu_pkg::*;
#(
    parameter int          SYNC_W         = 32,
    parameter logic [63:0] SYNC_WORD      = DEFAULT_ASM,
    parameter int          BITS_PER_FRAME = 8192,
    parameter int          NUM_FRAMES     = 8,
    parameter int          LOCK_THRESH    = 224
) (
    input  logic                                           clk,
    input  logic                                           rst_in,
    input  logic                                           bit_in,
    input  logic                                           valid_in,
    output logic                                           ready_out,
    output logic                                           valid_out,
    input  logic                                           ready_in,
    output logic [ofs_width(BITS_PER_FRAME)-1:0]           bit_offset,
    output logic [acc_width(NUM_FRAMES, SYNC_W)-1:0]       max_weight,
    output logic                                           inverted_out,
    output logic                                           locked_out,
    output logic                                           busy_out
);

    localparam int OFS_W      = ofs_width(BITS_PER_FRAME);
    localparam int ACC_W      = acc_width(NUM_FRAMES, SYNC_W);
    localparam int SC_W       = $clog2(SYNC_W + 1);
    localparam int PASS_W     = $clog2(NUM_FRAMES);
    localparam int TOTAL_BITS = NUM_FRAMES * BITS_PER_FRAME + SYNC_W - 1;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

    state_t state, state_next;

    logic [CNT_W-1:0]   bit_cnt, idx;
    logic [SYNC_W-1:0]  window;
    logic [OFS_W-1:0]   addr_cnt;
    logic [PASS_W-1:0]  pass_cnt;
    logic               accept, score_en, last_bit;

    logic               s0_valid, s0_first, s0_last, s0_final;
    logic [OFS_W-1:0]   s0_addr;
    logic               s1_valid, s1_first, s1_last, s1_final;
    logic [OFS_W-1:0]   s1_addr;
    logic               s2_final;

    logic [SC_W-1:0]    score;
    logic [2*ACC_W-1:0] ram_rd, ram_wr, ram_unused_b;
    logic [ACC_W-1:0]   score_true, score_inv, acc_true, acc_inv, cand;
    logic               cand_inv;

    logic [OFS_W-1:0]   best_offset;
    logic [ACC_W-1:0]   best_weight;
    logic               best_inv, best_lock;

    assign idx      = (state == IDLE) ? '0 : bit_cnt;
    assign accept   = valid_in && ready_out;
    assign score_en = idx >= CNT_W'(SYNC_W - 1);
    assign last_bit = idx == CNT_W'(TOTAL_BITS - 1);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_out  = 1'b0;
        valid_out  = 1'b0;
        busy_out   = 1'b1;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                busy_out  = 1'b0;
                if (valid_in) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                ready_out = bit_cnt != CNT_W'(TOTAL_BITS);
                if (s2_final) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_out = 1'b1;
                if (ready_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    asm_popcount_corr #(
        .SYNC_W   (SYNC_W),
        .SYNC_WORD(SYNC_WORD)
    ) corr (
        .clk   (clk),
        .rst_in(rst_in),
        .window(window),
        .score (score)
    );

    // Port A reads in stage 0; port B writes the updated sums back one cycle later.
    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH(2 * ACC_W),
        .RAM_DEPTH(BITS_PER_FRAME)
    ) acc_ram (
        .clka (clk),
        .clkb (clk),
        .addra(s0_addr),
        .addrb(s1_addr),
        .dina ('0),
        .dinb (ram_wr),
        .wea  (1'b0),
        .web  (s1_valid),
        .ena  (1'b1),
        .enb  (1'b1),
        .douta(ram_rd),
        .doutb(ram_unused_b)
    );

    always_comb begin
        score_true = ACC_W'(score);
        score_inv  = ACC_W'(SYNC_W) - score_true;
        acc_true   = s1_first ? score_true : ram_rd[2*ACC_W-1:ACC_W] + score_true;
        acc_inv    = s1_first ? score_inv  : ram_rd[ACC_W-1:0] + score_inv;
        ram_wr     = {acc_true, acc_inv};
        cand_inv   = acc_inv > acc_true;
        cand       = cand_inv ? acc_inv : acc_true;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt     <= '0;
            window      <= '0;
            addr_cnt    <= '0;
            pass_cnt    <= '0;
            s0_valid    <= 1'b0;
            s0_first    <= 1'b0;
            s0_last     <= 1'b0;
            s0_final    <= 1'b0;
            s0_addr     <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_final    <= 1'b0;
            s1_addr     <= '0;
            s2_final    <= 1'b0;
            best_offset <= '0;
            best_weight <= '0;
            best_inv    <= 1'b0;
            best_lock   <= 1'b0;
        end else begin
            s0_valid <= accept && score_en;
            s0_addr  <= addr_cnt;
            s0_first <= pass_cnt == '0;
            s0_last  <= pass_cnt == PASS_W'(NUM_FRAMES - 1);
            s0_final <= last_bit;
            s1_valid <= s0_valid;
            s1_addr  <= s0_addr;
            s1_first <= s0_first;
            s1_last  <= s0_last;
            s1_final <= s0_final;
            s2_final <= s1_valid && s1_final;

            if (accept) begin
                window  <= {window[SYNC_W-2:0], bit_in};
                bit_cnt <= idx + CNT_W'(1);
            end

            // The bit that starts a search never scores, so counters and best can be cleared here.
            if (accept && state == IDLE) begin
                addr_cnt    <= '0;
                pass_cnt    <= '0;
                best_offset <= '0;
                best_weight <= '0;
                best_inv    <= 1'b0;
                best_lock   <= 1'b0;
            end else if (accept && score_en) begin
                if (addr_cnt == OFS_W'(BITS_PER_FRAME - 1)) begin
                    addr_cnt <= '0;
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end else begin
                    addr_cnt <= addr_cnt + OFS_W'(1);
                end
            end

            if (s1_valid && s1_last && cand > best_weight) begin
                best_offset <= s1_addr;
                best_weight <= cand;
                best_inv    <= cand_inv;
                best_lock   <= int'(cand) >= LOCK_THRESH;
            end
        end
    end

    assign bit_offset   = best_offset;
    assign max_weight   = best_weight;
    assign inverted_out = best_inv;
    assign locked_out   = best_lock;

endmodule

// File: tb/tb_cadu_asm_search.sv
// Randomised bench for cadu_asm_search against a direct offset-by-offset correlation model.
module tb_cadu_asm_search;

    localparam int SW    = 32;
    localparam int BPF   = 64;
    localparam int NF    = 4;
    localparam int LT    = 120;
    localparam int TOTAL = NF * BPF + SW - 1;

    logic       clk = 1'b0;
    logic       rst_in, bit_in, valid_in, ready_in;
    logic       ready_out, valid_out, inverted_out, locked_out, busy_out;
    logic [5:0] bit_offset;
    logic [7:0] max_weight;

    cadu_asm_search #(
        .SYNC_W        (SW),
        .SYNC_WORD     (64'h1ACFFC1D),
        .BITS_PER_FRAME(BPF),
        .NUM_FRAMES    (NF),
        .LOCK_THRESH   (LT)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .bit_in      (bit_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .bit_offset  (bit_offset),
        .max_weight  (max_weight),
        .inverted_out(inverted_out),
        .locked_out  (locked_out),
        .busy_out    (busy_out)
    );

    always #5 clk = ~clk;

    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    logic        stream [TOTAL];
    logic [31:0] asmWord = 32'h1ACFFC1D;
    int          checkCount = 0;
    int          passCount  = 0;
    int          refOff, refW;
    logic        refInv, refLock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // mode 0: random only, 1: true marker at ofs in every frame, 2: inverted marker
    task automatic buildStream(input int ofs, input int mode);
        for (int i = 0; i < TOTAL; i++) stream[i] = 1'($urandom_range(0, 1));
        if (mode != 0) begin
            for (int f = 0; f < NF; f++)
                for (int j = 0; j < SW; j++)
                    stream[f*BPF + ofs + j] = (mode == 1) ? asmWord[SW-1-j] : ~asmWord[SW-1-j];
        end
    endtask

    task automatic computeRef();
        int best = 0;
        refOff = 0; refInv = 1'b0;
        for (int o = 0; o < BPF; o++) begin
            int t = 0;
            int inv, c;
            for (int f = 0; f < NF; f++)
                for (int j = 0; j < SW; j++)
                    if (stream[f*BPF + o + j] == asmWord[SW-1-j]) t++;
            inv = NF * SW - t;
            c = (inv > t) ? inv : t;
            if (c > best) begin
                best = c; refOff = o; refInv = inv > t;
            end
        end
        refW = best;
        refLock = best >= LT;
    endtask

    task automatic applyStimulus(input bit toggle, input int stopAfter, output int lastAccept);
        int   sent = 0;
        int   guard = 0;
        bit   phase = 0;
        logic acc;
        lastAccept = 0;
        while (sent < stopAfter && guard < 4 * TOTAL) begin
            if (toggle && phase) begin
                valid_in = 1'b0;
                bit_in   = 1'($urandom_range(0, 1));
            end else begin
                valid_in = 1'b1;
                bit_in   = stream[sent];
            end
            phase = ~phase;
            acc = valid_in && ready_out;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                lastAccept = cycleCount;
            end
            guard++;
        end
        if (sent < stopAfter) checkOutput("send_timeout", sent, stopAfter);
        valid_in = 1'($urandom_range(0, 1));
        bit_in   = 1'($urandom_range(0, 1));
    endtask

    task automatic runSearch(input string name, input bit toggle, input int holdCycles,
                             input int expOff, input logic expInv);
        int         lastAccept;
        int         waited = 0;
        bit         seen = 0;
        bit         stableOk = 1;
        logic [5:0] hOff;
        logic [7:0] hW;
        logic       hInv, hLock;
        ready_in = (holdCycles == 0);
        computeRef();
        applyStimulus(toggle, TOTAL, lastAccept);
        while (!seen && waited < 20) begin
            if (valid_out) seen = 1;
            else begin
                @(posedge clk); #1;
                waited++;
            end
        end
        checkOutput({name, "_valid_seen"}, seen, 1);
        checkOutput({name, "_latency"}, cycleCount - lastAccept, 3);
        checkOutput({name, "_ready_done"}, ready_out, 0);
        checkOutput({name, "_busy_done"}, busy_out, 1);
        checkOutput({name, "_offset_model"}, bit_offset, refOff);
        checkOutput({name, "_weight_model"}, max_weight, refW);
        checkOutput({name, "_inv_model"}, inverted_out, refInv);
        checkOutput({name, "_lock_model"}, locked_out, refLock);
        if (expOff >= 0) begin
            checkOutput({name, "_offset"}, bit_offset, expOff);
            checkOutput({name, "_weight"}, max_weight, NF * SW);
            checkOutput({name, "_inverted"}, inverted_out, expInv);
            checkOutput({name, "_locked"}, locked_out, 1);
        end
        if (holdCycles > 0) begin
            hOff = bit_offset; hW = max_weight; hInv = inverted_out; hLock = locked_out;
            repeat (holdCycles) begin
                @(posedge clk); #1;
                valid_in = 1'($urandom_range(0, 1));
                if (!valid_out || ready_out || bit_offset != hOff || max_weight != hW ||
                    inverted_out != hInv || locked_out != hLock)
                    stableOk = 0;
            end
            checkOutput({name, "_hold_stable"}, stableOk, 1);
            ready_in = 1'b1;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        checkOutput({name, "_valid_dropped"}, valid_out, 0);
        checkOutput({name, "_idle_ready"}, ready_out, 1);
        checkOutput({name, "_idle_busy"}, busy_out, 0);
    endtask

    initial begin
        int la;
        rst_in = 1'b1; valid_in = 1'b0; bit_in = 1'b0; ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", ready_out, 1);
        checkOutput("reset_valid", valid_out, 0);
        checkOutput("reset_busy", busy_out, 0);
        checkOutput("reset_offset", bit_offset, 0);
        checkOutput("reset_weight", max_weight, 0);
        checkOutput("reset_locked", locked_out, 0);
        rst_in = 1'b0;
        @(posedge clk); #1;

        buildStream(10, 1);
        runSearch("true10", 0, 0, 10, 1'b0);
        buildStream(50, 1);
        runSearch("wrap50", 0, 0, 50, 1'b0);
        buildStream(5, 2);
        runSearch("inv5", 0, 0, 5, 1'b1);
        buildStream(0, 0);
        runSearch("noise", 0, 0, -1, 1'b0);
        checkOutput("noise_unlocked", locked_out, 0);

        buildStream(10, 1);
        runSearch("gappy10", 1, 20, 10, 1'b0);
        buildStream(10, 1);
        runSearch("b2b10", 0, 0, 10, 1'b0);

        buildStream(10, 1);
        ready_in = 1'b1;
        applyStimulus(0, 150, la);
        checkOutput("mid_busy", busy_out, 1);
        #3 rst_in = 1'b1;
        valid_in = 1'b0;
        #1;
        checkOutput("midrst_ready", ready_out, 1);
        checkOutput("midrst_busy", busy_out, 0);
        checkOutput("midrst_valid", valid_out, 0);
        checkOutput("midrst_weight", max_weight, 0);
        #2 rst_in = 1'b0;
        @(posedge clk); #1;
        buildStream(33, 1);
        runSearch("after_rst33", 0, 0, 33, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
